// File: rtl/step_seq_pkg.sv
// Shared types for the step sequencer: operating modes and size limits.
// Pure declarations; no timing or flow-control behaviour.
package step_seq_pkg;

  localparam int MAX_STEPS  = 64;
  localparam int MAX_VOICES = 16;

  typedef enum logic [1:0] {
    EDIT = 2'd0,
    PLAY = 2'd1,
    RAW  = 2'd2
  } sysmode_t;

  // The unused encoding 3 folds onto EDIT so it can never start playback.
  function automatic sysmode_t decode_mode(input logic [1:0] m);
    case (m)
      2'd1:    return PLAY;
      2'd2:    return RAW;
      default: return EDIT;
    endcase
  endfunction

endpackage

// File: rtl/tempo_tick.sv
// Tempo divider: tick is high for one cycle every period+1 enabled cycles, combinational off the count.
// No backpressure; an over-range count (period lowered mid-count) restarts at 0 without a tick.
module tempo_tick #(
  parameter int TICK_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              clr,
  input  logic [TICK_W-1:0] period,
  output logic              tick
);

  logic [TICK_W-1:0] count;

  assign tick = en && !clr && (count == period);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr || !en || count >= period) begin
      count <= '0;
    end else begin
      count <= count + TICK_W'(1);
    end
  end

endmodule

// File: rtl/step_sequencer_n.sv
// Drum-style step sequencer: register pattern, edit/clear, tempo playback and raw live triggers.
// trig/step_strobe registered (1 cycle); no backpressure. STEP_SEQ_LOOP_LEN_EN adds loop_len.
module step_sequencer_n
  import step_seq_pkg::*;
#(
  parameter int NUM_STEPS  = 16,
  parameter int NUM_VOICES = 4,
  parameter int TICK_W     = 16,
  localparam int SW        = $clog2(NUM_STEPS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            mode,
  input  logic [TICK_W-1:0]     tick_period,
  input  logic [SW-1:0]         edit_idx,
  input  logic [NUM_VOICES-1:0] edit_tgl,
  input  logic                  edit_strobe,
  input  logic                  clear,
  input  logic [NUM_VOICES-1:0] raw_trig,
`ifdef STEP_SEQ_LOOP_LEN_EN
  input  logic [SW:0]           loop_len,
`endif
  output logic [SW-1:0]         step_pos,
  output logic                  step_strobe,
  output logic [NUM_VOICES-1:0] trig,
  output logic [NUM_VOICES-1:0] edit_row
);

  sysmode_t              mode_cur;
  sysmode_t              mode_q;
  logic                  play;
  logic                  play_entry;
  logic                  advance;
  logic [SW-1:0]         pos_nxt;
  logic [SW-1:0]         rd_idx;
  logic [NUM_VOICES-1:0] pattern [NUM_STEPS];
  logic [NUM_VOICES-1:0] raw_q;

  assign mode_cur   = decode_mode(mode);
  assign play       = (mode_cur == PLAY);
  assign play_entry = play && (mode_q != PLAY);

  tempo_tick #(.TICK_W(TICK_W)) u_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (play),
    .clr    (play_entry),
    .period (tick_period),
    .tick   (advance)
  );

`ifdef STEP_SEQ_LOOP_LEN_EN
  localparam logic [SW:0] STEPS_FULL = (SW+1)'(NUM_STEPS);
  logic [SW:0] loop_eff;
  logic [SW:0] pos_inc;

  // Out-of-range lengths fall back to the full pattern; positions past the loop restart at 0.
  always_comb begin
    pos_inc  = {1'b0, step_pos} + (SW+1)'(1);
    loop_eff = (loop_len == '0 || loop_len > STEPS_FULL) ? STEPS_FULL : loop_len;
    pos_nxt  = (pos_inc >= loop_eff) ? '0 : pos_inc[SW-1:0];
  end
`else
  assign pos_nxt = step_pos + SW'(1);
`endif

  assign rd_idx   = play_entry ? '0 : pos_nxt;
  assign edit_row = pattern[edit_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_STEPS; i++) pattern[i] <= '0;
    end else if (clear) begin
      for (int i = 0; i < NUM_STEPS; i++) pattern[i] <= '0;
    end else if (mode_cur == EDIT && edit_strobe) begin
      pattern[edit_idx] <= pattern[edit_idx] ^ edit_tgl;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_pos    <= '0;
      step_strobe <= 1'b0;
      trig        <= '0;
      raw_q       <= '0;
      mode_q      <= EDIT;
    end else begin
      mode_q      <= mode_cur;
      raw_q       <= raw_trig;
      step_strobe <= 1'b0;
      trig        <= '0;
      case (mode_cur)
        PLAY: begin
          if (play_entry || advance) begin
            step_pos    <= rd_idx;
            step_strobe <= 1'b1;
            // A clear landing on the same edge must silence this step too.
            trig        <= clear ? '0 : pattern[rd_idx];
          end
        end
        RAW:     trig <= raw_trig & ~raw_q;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_step_sequencer_n.sv
// Directed bench for step_sequencer_n at default parameters; loop-length vectors need STEP_SEQ_LOOP_LEN_EN.
module tb_step_sequencer_n;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  mode;
  logic [15:0] tick_period;
  logic [3:0]  edit_idx;
  logic [3:0]  edit_tgl;
  logic        edit_strobe;
  logic        clear;
  logic [3:0]  raw_trig;
`ifdef STEP_SEQ_LOOP_LEN_EN
  logic [4:0]  loop_len;
`endif
  logic [3:0]  step_pos;
  logic        step_strobe;
  logic [3:0]  trig;
  logic [3:0]  edit_row;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  step_sequencer_n dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mode        (mode),
    .tick_period (tick_period),
    .edit_idx    (edit_idx),
    .edit_tgl    (edit_tgl),
    .edit_strobe (edit_strobe),
    .clear       (clear),
    .raw_trig    (raw_trig),
`ifdef STEP_SEQ_LOOP_LEN_EN
    .loop_len    (loop_len),
`endif
    .step_pos    (step_pos),
    .step_strobe (step_strobe),
    .trig        (trig),
    .edit_row    (edit_row)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic edit(input logic [3:0] idx, input logic [3:0] tgl);
    edit_idx    = idx;
    edit_tgl    = tgl;
    edit_strobe = 1'b1;
    step();
    edit_strobe = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; mode = 2'd0; tick_period = '0; edit_idx = '0; edit_tgl = '0;
    edit_strobe = 1'b0; clear = 1'b0; raw_trig = '0;
`ifdef STEP_SEQ_LOOP_LEN_EN
    loop_len = '0;
`endif
    #2;
    check("rst_step_pos", step_pos, 0);
    check("rst_strobe", step_strobe, 0);
    check("rst_trig", trig, 0);
    check("rst_edit_row", edit_row, 0);
    step(2);
    rst_n = 1'b1;
    step();

    // Edit toggles, including mode 3 behaving as EDIT
    edit(4'd3, 4'b0101);
    check("edit_set", edit_row, 4'b0101);
    edit(4'd3, 4'b0101);
    check("edit_untoggle", edit_row, 4'b0000);
    mode = 2'd3;
    edit(4'd6, 4'b1001);
    check("mode3_edit", edit_row, 4'b1001);
    edit(4'd6, 4'b1001);
    mode = 2'd0;
    edit(4'd0, 4'b0001);
    edit(4'd1, 4'b0010);

    // Playback at tick_period=3; an edit strobe on the entry cycle must be ignored
    tick_period = 16'd3;
    mode = 2'd1;
    edit_idx = 4'd5; edit_tgl = 4'hF; edit_strobe = 1'b1;
    step();
    edit_strobe = 1'b0;
    check("entry_trig", trig, 4'b0001);
    check("entry_strobe", step_strobe, 1);
    check("entry_pos", step_pos, 0);
    check("play_edit_ignored", edit_row, 0);
    step();
    check("gap_trig", trig, 0);
    check("gap_strobe", step_strobe, 0);
    step(3);
    check("step1_trig", trig, 4'b0010);
    check("step1_pos", step_pos, 1);
    check("step1_strobe", step_strobe, 1);
    step(56);
    check("pos15", step_pos, 15);
    step(4);
    check("wrap_pos", step_pos, 0);
    check("wrap_trig", trig, 4'b0001);
    step(4);
    check("after_wrap_pos", step_pos, 1);

    // Leaving PLAY holds position and stops strobes
    mode = 2'd0;
    step(6);
    check("leave_pos_hold", step_pos, 1);
    check("leave_strobe", step_strobe, 0);
    check("leave_trig", trig, 0);

    // tick_period=0: advance every cycle
    tick_period = 16'd0;
    mode = 2'd1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("fast_pos", step_pos, i);
      check("fast_strobe", step_strobe, 1);
      check("fast_trig", trig, (i == 0) ? 4'b0001 : (i == 1) ? 4'b0010 : 4'b0000);
    end

    // Clear during PLAY silences all later steps, including steps 0 and 1
    clear = 1'b1;
    step();
    clear = 1'b0;
    check("clear_edge_trig", trig, 0);
    for (int i = 0; i < 20; i++) begin
      step();
      check("post_clear_trig", trig, 0);
    end
    mode = 2'd0;
    step();

    // Clear wins over a simultaneous edit
    edit(4'd2, 4'hF);
    check("row2_set", edit_row, 4'hF);
    edit_idx = 4'd2; edit_tgl = 4'b0011; edit_strobe = 1'b1; clear = 1'b1;
    step();
    edit_strobe = 1'b0; clear = 1'b0;
    for (int i = 0; i < 16; i++) begin
      edit_idx = 4'(i);
      #1;
      check("clear_wins_row", edit_row, 0);
    end

    // RAW: one pulse per rising edge, one cycle late
    mode = 2'd2;
    step();
    raw_trig = 4'b1000;
    step();
    check("raw_pulse", trig, 4'b1000);
    for (int i = 1; i < 10; i++) begin
      step();
      check("raw_held", trig, 0);
    end
    raw_trig = '0;
    step();
    check("raw_pos_hold", step_pos, 9);
    check("raw_strobe", step_strobe, 0);

    // Period lowered below the running count: wrap without an advance
    mode = 2'd0;
    step();
    tick_period = 16'd7;
    mode = 2'd1;
    step();
    check("p7_entry_strobe", step_strobe, 1);
    step(5);
    check("p7_pos", step_pos, 0);
    tick_period = 16'd2;
    step();
    check("shrink_no_strobe", step_strobe, 0);
    check("shrink_pos", step_pos, 0);
    step(2);
    check("shrink_wait_pos", step_pos, 0);
    step();
    check("shrink_adv_pos", step_pos, 1);
    check("shrink_adv_strobe", step_strobe, 1);

    // Asynchronous reset mid-play, then release with mode=PLAY counts as entry
    mode = 2'd0;
    step();
    edit(4'd0, 4'b0001);
    edit(4'd2, 4'b0100);
    tick_period = 16'd0;
    mode = 2'd1;
    step(3);
    check("pre_rst_trig", trig, 4'b0100);
    rst_n = 1'b0;
    #1;
    check("arst_pos", step_pos, 0);
    check("arst_trig", trig, 0);
    check("arst_strobe", step_strobe, 0);
    check("arst_row", edit_row, 0);
    step();
    rst_n = 1'b1;
    step();
    check("rst_entry_strobe", step_strobe, 1);
    check("rst_entry_pos", step_pos, 0);
    step();
    check("rst_entry_next_pos", step_pos, 1);

`ifdef STEP_SEQ_LOOP_LEN_EN
    mode = 2'd0;
    step();
    loop_len = 5'd5;
    mode = 2'd1;
    for (int i = 0; i < 6; i++) begin
      step();
      check("loop5_pos", step_pos, i % 5);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
